// File: rtl/puf_soc_ro_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : puf_soc_ro_pair_sequencer
// Brief    : Ring-oscillator pair sequencer for the PUF block. Drives a 2-hot
//            RO enable mask and walks one pair, a full a<b sweep or an
//            adjacent (i,i+1) sweep. Each pair goes through settle,
//            measurement start and measurement done, with a watchdog on the
//            measurement.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module puf_soc_ro_pair_sequencer #(
  parameter int MUX_LENGTH = 16,
  parameter int SETTLE_W   = 8,
  parameter int TIMEOUT_W  = 16,
  localparam int SEL_W     = $clog2(MUX_LENGTH),
  localparam int PAIR_W    = $clog2(MUX_LENGTH * MUX_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [SEL_W-1:0]      i_sel_mux_0,
  input  logic [SEL_W-1:0]      i_sel_mux_1,
  input  logic [SETTLE_W-1:0]   i_settle_cycles,
  input  logic                  i_meas_done,
  input  logic                  i_abort,
  output logic [MUX_LENGTH-1:0] o_puf_en,
  output logic [SEL_W-1:0]      o_sel_mux_0,
  output logic [SEL_W-1:0]      o_sel_mux_1,
  output logic [PAIR_W-1:0]     o_pair_idx,
  output logic                  o_meas_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err_sel,
  output logic                  o_err_timeout
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_ENABLE = 3'd1;
  localparam logic [2:0] c_MSTART = 3'd2;
  localparam logic [2:0] c_WAIT   = 3'd3;
  localparam logic [2:0] c_GAP    = 3'd4;
  localparam logic [2:0] c_DONE   = 3'd5;

  localparam logic [1:0] c_MODE_SINGLE = 2'b00;
  localparam logic [1:0] c_MODE_FULL   = 2'b01;
  localparam logic [1:0] c_MODE_RSVD   = 2'b11;

  localparam logic [SEL_W-1:0]      c_SEL_LAST   = SEL_W'(MUX_LENGTH - 1);
  localparam logic [SEL_W-1:0]      c_SEL_PENULT = SEL_W'(MUX_LENGTH - 2);
  localparam logic [SEL_W:0]        c_SEL_LIMIT  = (SEL_W + 1)'(MUX_LENGTH);
  localparam logic [SEL_W-1:0]      c_SEL_ONE    = SEL_W'(1);
  localparam logic [MUX_LENGTH-1:0] c_EN_ONE     = MUX_LENGTH'(1);
  // Last WAIT cycle index before the watchdog fires (limit - 1, counted from 0)
  localparam logic [TIMEOUT_W-1:0]  c_WDOG_LAST  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [2:0]            r_state,       w_state_nxt;
  logic [1:0]            r_mode,        w_mode_nxt;
  logic [SETTLE_W-1:0]   r_settle,      w_settle_nxt;
  logic [SETTLE_W-1:0]   r_settle_cnt,  w_settle_cnt_nxt;
  logic [TIMEOUT_W-1:0]  r_wdog,        w_wdog_nxt;
  logic [SEL_W-1:0]      r_sel_a,       w_sel_a_nxt;
  logic [SEL_W-1:0]      r_sel_b,       w_sel_b_nxt;
  logic [PAIR_W-1:0]     r_pair_idx,    w_pair_idx_nxt;
  logic                  r_err_sel,     w_err_sel_nxt;
  logic                  r_err_timeout, w_err_timeout_nxt;
  logic [MUX_LENGTH-1:0] r_puf_en,      w_puf_en_nxt;
  logic                  r_meas_start,  w_meas_start_nxt;
  logic                  r_busy,        w_busy_nxt;
  logic                  r_done,        w_done_nxt;

  logic                  w_sel_oob;
  logic                  w_req_invalid;
  logic                  w_last_pair;
  logic                  w_step_a;
  logic [SEL_W-1:0]      w_sel_a_adv;
  logic [SEL_W-1:0]      w_sel_b_adv;

  // Selection checks only matter in single mode; sweeps generate their own pairs
  assign w_sel_oob     = ({1'b0, i_sel_mux_0} >= c_SEL_LIMIT) ||
                         ({1'b0, i_sel_mux_1} >= c_SEL_LIMIT);
  assign w_req_invalid = (i_mode == c_MODE_RSVD) ||
                         ((i_mode == c_MODE_SINGLE) &&
                          ((i_sel_mux_0 == i_sel_mux_1) || w_sel_oob));

  // Both sweeps end on the pair whose first RO is N-2
  assign w_last_pair = (r_mode == c_MODE_SINGLE) || (r_sel_a == c_SEL_PENULT);

  // Adjacent always steps a; full sweep steps a only when b has reached the top
  assign w_step_a    = (r_mode != c_MODE_FULL) || (r_sel_b == c_SEL_LAST);
  assign w_sel_a_adv = w_step_a ? (r_sel_a + 1'b1) : r_sel_a;
  assign w_sel_b_adv = w_step_a ? (w_sel_a_adv + 1'b1) : (r_sel_b + 1'b1);

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_IDLE;
      r_mode        <= '0;
      r_settle      <= '0;
      r_settle_cnt  <= '0;
      r_wdog        <= '0;
      r_sel_a       <= '0;
      r_sel_b       <= '0;
      r_pair_idx    <= '0;
      r_err_sel     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_puf_en      <= '0;
      r_meas_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mode        <= w_mode_nxt;
      r_settle      <= w_settle_nxt;
      r_settle_cnt  <= w_settle_cnt_nxt;
      r_wdog        <= w_wdog_nxt;
      r_sel_a       <= w_sel_a_nxt;
      r_sel_b       <= w_sel_b_nxt;
      r_pair_idx    <= w_pair_idx_nxt;
      r_err_sel     <= w_err_sel_nxt;
      r_err_timeout <= w_err_timeout_nxt;
      r_puf_en      <= w_puf_en_nxt;
      r_meas_start  <= w_meas_start_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
    end
  end

  // Next state plus pair, counter and error-flag updates
  always_comb begin
    w_state_nxt       = r_state;
    w_mode_nxt        = r_mode;
    w_settle_nxt      = r_settle;
    w_settle_cnt_nxt  = r_settle_cnt;
    w_wdog_nxt        = r_wdog;
    w_sel_a_nxt       = r_sel_a;
    w_sel_b_nxt       = r_sel_b;
    w_pair_idx_nxt    = r_pair_idx;
    w_err_sel_nxt     = r_err_sel;
    w_err_timeout_nxt = r_err_timeout;
    case (r_state)
      c_IDLE: begin
        if (i_start) begin
          w_mode_nxt        = i_mode;
          w_settle_nxt      = i_settle_cycles;
          w_settle_cnt_nxt  = '0;
          w_wdog_nxt        = '0;
          w_pair_idx_nxt    = '0;
          w_err_sel_nxt     = w_req_invalid;
          w_err_timeout_nxt = 1'b0;
          if (w_req_invalid) begin
            w_state_nxt = c_DONE;
          end else begin
            w_state_nxt = c_ENABLE;
            if (i_mode == c_MODE_SINGLE) begin
              w_sel_a_nxt = i_sel_mux_0;
              w_sel_b_nxt = i_sel_mux_1;
            end else begin
              w_sel_a_nxt = '0;
              w_sel_b_nxt = c_SEL_ONE;
            end
          end
        end
      end
      c_ENABLE: begin
        if (i_abort) begin
          w_state_nxt = c_IDLE;
        end else if (r_settle_cnt == r_settle) begin
          w_state_nxt = c_MSTART;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt + 1'b1;
        end
      end
      c_MSTART: begin
        if (i_abort) begin
          w_state_nxt = c_IDLE;
        end else begin
          w_state_nxt = c_WAIT;
          w_wdog_nxt  = '0;
        end
      end
      c_WAIT: begin
        // A completion arriving on the final watchdog cycle still counts
        if (i_abort) begin
          w_state_nxt = c_IDLE;
        end else if (i_meas_done) begin
          w_state_nxt = c_GAP;
        end else if (r_wdog == c_WDOG_LAST) begin
          w_state_nxt       = c_DONE;
          w_err_timeout_nxt = 1'b1;
        end else begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      c_GAP: begin
        if (i_abort) begin
          w_state_nxt = c_IDLE;
        end else if (w_last_pair) begin
          w_state_nxt = c_DONE;
        end else begin
          w_state_nxt      = c_ENABLE;
          w_sel_a_nxt      = w_sel_a_adv;
          w_sel_b_nxt      = w_sel_b_adv;
          w_pair_idx_nxt   = r_pair_idx + 1'b1;
          w_settle_cnt_nxt = '0;
        end
      end
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output values decoded from the upcoming state so they register with it
  always_comb begin
    w_puf_en_nxt     = '0;
    w_meas_start_nxt = (w_state_nxt == c_MSTART);
    w_busy_nxt       = (w_state_nxt != c_IDLE) && (w_state_nxt != c_DONE);
    w_done_nxt       = (w_state_nxt == c_DONE);
    if ((w_state_nxt == c_ENABLE) || (w_state_nxt == c_MSTART) ||
        (w_state_nxt == c_WAIT)) begin
      w_puf_en_nxt = (c_EN_ONE << w_sel_a_nxt) | (c_EN_ONE << w_sel_b_nxt);
    end
  end

  assign o_puf_en      = r_puf_en;
  assign o_sel_mux_0   = r_sel_a;
  assign o_sel_mux_1   = r_sel_b;
  assign o_pair_idx    = r_pair_idx;
  assign o_meas_start  = r_meas_start;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err_sel     = r_err_sel;
  assign o_err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_puf_soc_ro_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_puf_soc_ro_pair_sequencer
// Brief    : Scoreboard bench for the RO pair sequencer. A driver walks each
//            sequence from a pair-list model and queues the expected
//            measurement-start and done events; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_puf_soc_ro_pair_sequencer;

  localparam int N          = 6;
  localparam int SW         = 8;
  localparam int TW         = 4;
  localparam int SEL_W      = $clog2(N);
  localparam int PAIR_W     = $clog2(N * N);
  localparam int WDOG_WAITS = (1 << TW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [1:0]        i_mode = '0;
  logic [SEL_W-1:0]  i_sel_mux_0 = '0;
  logic [SEL_W-1:0]  i_sel_mux_1 = '0;
  logic [SW-1:0]     i_settle_cycles = '0;
  logic              i_meas_done = 1'b0;
  logic              i_abort = 1'b0;
  logic [N-1:0]      o_puf_en;
  logic [SEL_W-1:0]  o_sel_mux_0;
  logic [SEL_W-1:0]  o_sel_mux_1;
  logic [PAIR_W-1:0] o_pair_idx;
  logic              o_meas_start;
  logic              o_busy;
  logic              o_done;
  logic              o_err_sel;
  logic              o_err_timeout;

  puf_soc_ro_pair_sequencer #(
    .MUX_LENGTH (N),
    .SETTLE_W   (SW),
    .TIMEOUT_W  (TW)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .i_mode          (i_mode),
    .i_sel_mux_0     (i_sel_mux_0),
    .i_sel_mux_1     (i_sel_mux_1),
    .i_settle_cycles (i_settle_cycles),
    .i_meas_done     (i_meas_done),
    .i_abort         (i_abort),
    .o_puf_en        (o_puf_en),
    .o_sel_mux_0     (o_sel_mux_0),
    .o_sel_mux_1     (o_sel_mux_1),
    .o_pair_idx      (o_pair_idx),
    .o_meas_start    (o_meas_start),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err_sel       (o_err_sel),
    .o_err_timeout   (o_err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int idx; int a; int b; } ms_t;
  typedef struct { int cyc; bit esel; bit eto; } dn_t;

  ms_t          q_ms[$];
  dn_t          q_dn[$];
  int           checks = 0;
  int           failures = 0;
  bit           mon_en = 1'b0;
  logic [N-1:0] exp_mask = '0;
  logic         exp_busy = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] pmask(input int a, input int b);
    logic [N-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    m[b] = 1'b1;
    return m;
  endfunction

  function automatic bit rb();
    return bit'($urandom & 1);
  endfunction

  // Monitor: per-cycle mask/busy, plus event pops for measurement start and done
  always @(negedge clk) begin
    ms_t e;
    dn_t d;
    if (mon_en) begin
      chk("puf_en", o_puf_en, exp_mask);
      chk("busy", o_busy, exp_busy);
      if (o_meas_start) begin
        if (q_ms.size() == 0) begin
          chk("unexpected_meas_start", 1, 0);
        end else begin
          e = q_ms.pop_front();
          chk("meas_start_cycle", cyc, e.cyc);
          chk("pair_idx", o_pair_idx, e.idx);
          chk("sel_mux_0", o_sel_mux_0, e.a);
          chk("sel_mux_1", o_sel_mux_1, e.b);
        end
      end
      if (o_done) begin
        if (q_dn.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          d = q_dn.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("err_sel", o_err_sel, d.esel);
          chk("err_timeout", o_err_timeout, d.eto);
        end
      end
    end
  end

  // One clock cycle of stimulus; config inputs get junk unless held for a start
  task automatic step(input bit st, input bit dn, input bit ab,
                      input logic [N-1:0] m, input bit b, input bit hold_cfg);
    i_start     = st;
    i_meas_done = dn;
    i_abort     = ab;
    exp_mask    = m;
    exp_busy    = b;
    if (!hold_cfg) begin
      i_mode          = 2'($urandom);
      i_sel_mux_0     = SEL_W'($urandom);
      i_sel_mux_1     = SEL_W'($urandom);
      i_settle_cycles = SW'($urandom);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_after_abort();
    chk("abort_busy", o_busy, 0);
    chk("abort_puf_en", o_puf_en, 0);
    chk("abort_done", o_done, 0);
    chk("abort_err_sel", o_err_sel, 0);
    chk("abort_err_timeout", o_err_timeout, 0);
  endtask

  // Plan one sequence from the pair list and drive it cycle by cycle.
  // ab_phase 0 aborts in the first ENABLE cycle, 1 aborts in WAIT with done high.
  task automatic run_seq(input int mode, input int s0, input int s1, input int s,
                         input int ab_pair, input int ab_phase, input int to_pair);
    int           pa[$];
    int           pb[$];
    int           m;
    int           d;
    bit           inval;
    logic [N-1:0] mk;
    inval = (mode == 3) || (mode == 0 && (s0 == s1 || s0 >= N || s1 >= N));
    if (mode == 0) begin
      pa.push_back(s0);
      pb.push_back(s1);
    end else if (mode == 1) begin
      for (int a = 0; a <= N - 2; a++)
        for (int b = a + 1; b <= N - 1; b++) begin
          pa.push_back(a);
          pb.push_back(b);
        end
    end else if (mode == 2) begin
      for (int i = 0; i <= N - 2; i++) begin
        pa.push_back(i);
        pb.push_back(i + 1);
      end
    end
    i_mode          = 2'(mode);
    i_sel_mux_0     = SEL_W'(s0);
    i_sel_mux_1     = SEL_W'(s1);
    i_settle_cycles = SW'(s);
    if (inval) begin
      q_dn.push_back('{cyc + 1, 1'b1, 1'b0});
      step(1'b1, rb(), rb(), '0, 1'b0, 1'b1);
      step(rb(), rb(), rb(), '0, 1'b0, 1'b0);
      return;
    end
    step(1'b1, rb(), rb(), '0, 1'b0, 1'b1);
    for (int k = 0; k < pa.size(); k++) begin
      mk = pmask(pa[k], pb[k]);
      if (k == ab_pair && ab_phase == 0) begin
        step(rb(), rb(), 1'b1, mk, 1'b1, 1'b0);
        idle_after_abort();
        return;
      end
      m = cyc + s + 1;
      q_ms.push_back('{m, k, pa[k], pb[k]});
      repeat (s + 1) step(rb(), rb(), 1'b0, mk, 1'b1, 1'b0);
      step(rb(), rb(), 1'b0, mk, 1'b1, 1'b0);
      if (k == to_pair) begin
        repeat (WDOG_WAITS) step(rb(), 1'b0, 1'b0, mk, 1'b1, 1'b0);
        q_dn.push_back('{cyc, 1'b0, 1'b1});
        step(rb(), rb(), rb(), '0, 1'b0, 1'b0);
        return;
      end
      d = $urandom_range(0, 10);
      repeat (d) step(rb(), 1'b0, 1'b0, mk, 1'b1, 1'b0);
      if (k == ab_pair) begin
        step(rb(), 1'b1, 1'b1, mk, 1'b1, 1'b0);
        idle_after_abort();
        return;
      end
      step(rb(), 1'b1, 1'b0, mk, 1'b1, 1'b0);
      step(rb(), rb(), 1'b0, '0, 1'b1, 1'b0);
      if (k == pa.size() - 1) begin
        q_dn.push_back('{cyc, 1'b0, 1'b0});
        step(rb(), rb(), rb(), '0, 1'b0, 1'b0);
        return;
      end
    end
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 2)) step(1'b0, rb(), rb(), '0, 1'b0, 1'b0);
  endtask

  initial begin
    int md;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_puf_en", o_puf_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_meas_start", o_meas_start, 0);
    chk("rst_err_sel", o_err_sel, 0);
    chk("rst_err_timeout", o_err_timeout, 0);
    chk("rst_pair_idx", o_pair_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_mask = '0;
    exp_busy = 1'b0;
    mon_en   = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    run_seq(0, 3, 5, 2, -1, 0, -1);  idle_gap();
    run_seq(0, 5, 5, 1, -1, 0, -1);  idle_gap();
    run_seq(0, 6, 1, 0, -1, 0, -1);  idle_gap();
    run_seq(0, 2, 7, 0, -1, 0, -1);  idle_gap();
    run_seq(3, 0, 1, 0, -1, 0, -1);  idle_gap();
    run_seq(1, 0, 0, 0, -1, 0, -1);  idle_gap();
    run_seq(2, 4, 4, 1, -1, 0, -1);  idle_gap();
    run_seq(1, 0, 0, 1, 2, 1, -1);   idle_gap();
    run_seq(0, 4, 0, 3, 0, 0, -1);   idle_gap();
    run_seq(0, 1, 2, 0, -1, 0, 0);   idle_gap();
    run_seq(0, 0, 5, 0, -1, 0, -1);  idle_gap();
    run_seq(2, 0, 0, 0, -1, 0, 2);   idle_gap();

    for (int r = 0; r < 24; r++) begin
      md = $urandom_range(0, 3);
      run_seq(md, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1,
              $urandom_range(0, 1),
              ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4) : -1);
      idle_gap();
    end

    // Asynchronous reset in the middle of a settle phase
    i_mode = 2'b00; i_sel_mux_0 = 3'd1; i_sel_mux_1 = 3'd4; i_settle_cycles = 8'd5;
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, pmask(1, 4), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, pmask(1, 4), 1'b1, 1'b0);
    chk("pre_reset_puf_en", o_puf_en, pmask(1, 4));
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_puf_en", o_puf_en, 0);
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_sel_mux_0", o_sel_mux_0, 0);
    chk("async_rst_sel_mux_1", o_sel_mux_1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_mask = '0;
    exp_busy = 1'b0;
    mon_en   = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    run_seq(2, 0, 0, 0, -1, 0, -1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    chk("ms_queue_drained", q_ms.size(), 0);
    chk("done_queue_drained", q_dn.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
